// File: rtl/pll_sup_pkg.sv
// Shared state type, widths and default parameters for the PLL lock supervisor.
package pll_sup_pkg;

   localparam int LOSS_W            = 8;
   localparam int DEF_RST_CYCLES    = 16;
   localparam int DEF_LOCK_TIMEOUT  = 4096;
   localparam int DEF_STABLE_CYCLES = 256;
   localparam int DEF_MAX_RETRIES   = 3;
   localparam int DEF_SYNC_STAGES   = 2;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Supervisor <-> PLL / system-reset signal bundle; master is the supervisor side.
interface pll_sup_if;
   import pll_sup_pkg::*;

   logic              LOCK;
   logic              PLL_RESETB;
   logic              SYS_RESET_N;
   logic              READY;
   logic              FAULT;
   logic [LOSS_W-1:0] LOSS_COUNT;

   modport master (
      input  LOCK,
      output PLL_RESETB, SYS_RESET_N, READY, FAULT, LOSS_COUNT
   );

   modport slave (
      output LOCK,
      input  PLL_RESETB, SYS_RESET_N, READY, FAULT, LOSS_COUNT
   );

endinterface

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, qualifies LOCK and releases the system reset.
// Define PLL_SUP_LOSS_COUNT_EN to build the saturating lock-loss counter.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
   input  logic      REFERENCECLK,
   input  logic      RESETN,
   pll_sup_if.master bus
);

   localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

   state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [RTY_W-1:0] r_retry, w_retry_nxt;
   logic             r_pll_resetb, r_sys_reset_n, r_ready, r_fault;
   logic             w_lock_s;

   sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .clk   (REFERENCECLK),
      .rst_n (RESETN),
      .i_d   (bus.LOCK),
      .o_q   (w_lock_s)
   );

   always_comb begin
      // NOTE: defaults first so no path through the case can infer a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_retry_nxt = r_retry;
      case (r_state)
         PLL_RST: begin
            if (r_cnt == RST_LAST) w_state_nxt = WAIT_LOCK;
            else                   w_cnt_nxt   = r_cnt + CNT_W'(1);
         end
         WAIT_LOCK: begin
            // Lock beats a timeout expiring in the same cycle.
            if (w_lock_s) begin
               w_state_nxt = STABLE;
            end else if (r_cnt == TMO_LAST) begin
               w_retry_nxt = r_retry + RTY_W'(1);
               w_state_nxt = (r_retry == RTY_LAST) ? FAULT : PLL_RST;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         STABLE: begin
            if (!w_lock_s) begin
               w_state_nxt = WAIT_LOCK;
            end else if (r_cnt == STB_LAST) begin
               w_state_nxt = RUN;
               w_retry_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         RUN: begin
            if (!w_lock_s) w_state_nxt = PLL_RST;
         end
         FAULT: begin
            w_state_nxt = FAULT;
         end
         default: w_state_nxt = PLL_RST;
      endcase
      if (w_state_nxt != r_state) w_cnt_nxt = '0;
   end

   // Outputs are decoded from the next state so they switch on the transition edge.
   always_ff @(posedge REFERENCECLK or negedge RESETN) begin
      if (!RESETN) begin
         r_state       <= PLL_RST;
         r_cnt         <= '0;
         r_retry       <= '0;
         r_pll_resetb  <= 1'b0;
         r_sys_reset_n <= 1'b0;
         r_ready       <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_retry       <= w_retry_nxt;
         r_pll_resetb  <= (w_state_nxt != PLL_RST) && (w_state_nxt != FAULT);
         r_sys_reset_n <= (w_state_nxt == RUN);
         r_ready       <= (w_state_nxt == RUN);
         r_fault       <= (w_state_nxt == FAULT);
      end
   end

   assign bus.PLL_RESETB  = r_pll_resetb;
   assign bus.SYS_RESET_N = r_sys_reset_n;
   assign bus.READY       = r_ready;
   assign bus.FAULT       = r_fault;

`ifdef PLL_SUP_LOSS_COUNT_EN
   logic [LOSS_W-1:0] r_loss_cnt;

   always_ff @(posedge REFERENCECLK or negedge RESETN) begin
      if (!RESETN) begin
         r_loss_cnt <= '0;
      end else if ((r_state == RUN) && !w_lock_s && (r_loss_cnt != '1)) begin
         r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
      end
   end

   assign bus.LOSS_COUNT = r_loss_cnt;
`else
   assign bus.LOSS_COUNT = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus random LOCK traffic vs a timestamp model.
module tb_pll_lock_supervisor;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 3;
   localparam int SYNC_STAGES   = 2;
   localparam int LOSS_MAX      = 255;

`ifdef PLL_SUP_LOSS_COUNT_EN
   localparam bit LOSS_EN = 1'b1;
`else
   localparam bit LOSS_EN = 1'b0;
`endif

   localparam int S_PLL = 0;
   localparam int S_SYS = 1;
   localparam int S_RDY = 2;
   localparam int S_FLT = 3;

   logic clk;
   logic rst_n;

   pll_sup_if bus ();

   pll_lock_supervisor #(
      .RST_CYCLES    (RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES),
      .SYNC_STAGES   (SYNC_STAGES)
   ) dut (
      .REFERENCECLK (clk),
      .RESETN       (rst_n),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: phase name, entry timestamp, and elapsed-time rules.
   int unsigned cyc;
   int unsigned t_entry;
   int unsigned retries;
   int unsigned losses;
   string       phase;
   bit          lq[$];
   int          low_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic void enter(input string p);
      phase   = p;
      t_entry = cyc;
   endfunction

   function automatic void model_reset();
      cyc     = 0;
      t_entry = 0;
      retries = 0;
      losses  = 0;
      phase   = "reset";
      lq.delete();
      for (int i = 0; i < SYNC_STAGES; i++) lq.push_back(1'b0);
   endfunction

   function automatic void model_edge(input bit lock_in);
      bit ls;
      ls = lq.pop_front();
      lq.push_back(lock_in);
      if (phase == "reset") begin
         if (cyc - t_entry >= RST_CYCLES) enter("wait");
      end else if (phase == "wait") begin
         if (ls) begin
            enter("stable");
         end else if (cyc - t_entry >= LOCK_TIMEOUT) begin
            retries++;
            enter((retries >= MAX_RETRIES) ? "fault" : "reset");
         end
      end else if (phase == "stable") begin
         if (!ls) begin
            enter("wait");
         end else if (cyc - t_entry >= STABLE_CYCLES) begin
            retries = 0;
            enter("run");
         end
      end else if (phase == "run") begin
         if (!ls) begin
            if (losses < LOSS_MAX) losses++;
            enter("reset");
         end
      end
   endfunction

   task automatic check_model();
      check("pll_resetb",  32'(bus.PLL_RESETB),  32'(!(phase == "reset" || phase == "fault")));
      check("sys_reset_n", 32'(bus.SYS_RESET_N), 32'(phase == "run"));
      check("ready",       32'(bus.READY),       32'(phase == "run"));
      check("fault",       32'(bus.FAULT),       32'(phase == "fault"));
      check("loss_count",  32'(bus.LOSS_COUNT),  LOSS_EN ? 32'(losses) : 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge(bus.LOCK);
      @(negedge clk);
      if (bus.PLL_RESETB === 1'b0) low_seen++;
      check_model();
   endtask

   function automatic logic out_sel(input int sel);
      case (sel)
         S_PLL:   return bus.PLL_RESETB;
         S_SYS:   return bus.SYS_RESET_N;
         S_RDY:   return bus.READY;
         default: return bus.FAULT;
      endcase
   endfunction

   task automatic wait_until(input int sel, input logic val, input int budget,
                             input string tag, output int n);
      n = 0;
      while (out_sel(sel) !== val && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(out_sel(sel)), 32'(val));
   endtask

   // Asserts reset off-edge, checks the asynchronous clear, releases on a falling edge.
   task automatic do_reset();
      rst_n    = 1'b0;
      bus.LOCK = 1'b0;
      #1;
      model_reset();
      check_model();
      repeat (3) @(negedge clk);
      check_model();
      rst_n = 1'b1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n    = 1'b1;
      bus.LOCK = 1'b0;
      #2;

      // Reset values and nominal bring-up.
      do_reset();
      check("reset_pll_resetb", 32'(bus.PLL_RESETB), 32'd0);
      check("reset_loss_count", 32'(bus.LOSS_COUNT), 32'd0);
      wait_until(S_PLL, 1'b1, 50, "nom_pll_release", n);
      check("nom_pll_low_len", n, RST_CYCLES);
      repeat (5) tick();
      bus.LOCK = 1'b1;
      wait_until(S_SYS, 1'b1, 60, "nom_sys_release", n);
      check("nom_lock_to_sys", n, SYNC_STAGES + STABLE_CYCLES + 1);
      check("nom_ready", 32'(bus.READY), 32'd1);

      // Lock loss in RUN, then relock.
      repeat (3) tick();
      bus.LOCK = 1'b0;
      wait_until(S_SYS, 1'b0, 20, "loss_sys_fall", n);
      check("loss_latency", n, SYNC_STAGES + 1);
      check("loss_pll_resetb", 32'(bus.PLL_RESETB), 32'd0);
      check("loss_count_one", 32'(bus.LOSS_COUNT), LOSS_EN ? 32'd1 : 32'd0);
      bus.LOCK = 1'b1;
      wait_until(S_RDY, 1'b1, 80, "relock_ready", n);

      // Reset asserted while qualifying in STABLE.
      bus.LOCK = 1'b0;
      wait_until(S_PLL, 1'b0, 20, "mid_loss", n);
      bus.LOCK = 1'b1;
      wait_until(S_PLL, 1'b1, 20, "mid_pll_release", n);
      repeat (3) tick();
      check("mid_not_ready", 32'(bus.READY), 32'd0);
      #2;
      do_reset();
      check("mid_loss_cleared", 32'(bus.LOSS_COUNT), 32'd0);
      wait_until(S_PLL, 1'b1, 50, "mid_restart", n);
      check("mid_restart_len", n, RST_CYCLES);

      // One-cycle LOCK glitch while in STABLE.
      low_seen = 0;
      bus.LOCK = 1'b1;
      repeat (5) tick();
      bus.LOCK = 1'b0;
      tick();
      bus.LOCK = 1'b1;
      wait_until(S_SYS, 1'b1, 60, "glitch_sys_release", n);
      check("glitch_lock_to_sys", n, SYNC_STAGES + STABLE_CYCLES + 1);
      check("glitch_pll_low_cycles", low_seen, 0);

      // Saturation: repeated randomized lock losses.
      for (int i = 0; i < LOSS_MAX + 5; i++) begin
         wait_until(S_RDY, 1'b1, 80, "sat_ready", n);
         repeat ($urandom_range(0, 3)) tick();
         bus.LOCK = 1'b0;
         repeat ($urandom_range(1, 4)) tick();
         bus.LOCK = 1'b1;
      end
      wait_until(S_RDY, 1'b1, 80, "sat_final_ready", n);
      check("sat_loss_count", 32'(bus.LOSS_COUNT), LOSS_EN ? 32'(LOSS_MAX) : 32'd0);

      // Lock never arrives: retries then sticky fault.
      do_reset();
      for (int p = 0; p < MAX_RETRIES; p++) begin
         wait_until(S_PLL, 1'b1, 50, "tmo_pulse_end", n);
         check("tmo_pulse_len", n, RST_CYCLES);
         wait_until(S_PLL, 1'b0, 50, "tmo_wait_end", n);
         check("tmo_wait_len", n, LOCK_TIMEOUT);
         check("tmo_fault", 32'(bus.FAULT), 32'(p == MAX_RETRIES - 1));
      end
      bus.LOCK = 1'b1;
      repeat (30) tick();
      check("fault_sticky", 32'(bus.FAULT), 32'd1);
      check("fault_pll_low", 32'(bus.PLL_RESETB), 32'd0);
      do_reset();
      check("fault_cleared", 32'(bus.FAULT), 32'd0);

      // Random LOCK segments against the model.
      for (int s = 0; s < 150; s++) begin
         bus.LOCK = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 30)) tick();
         if (phase == "fault") do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
